mem_arbiter: RTL

Shared memory port between the instruction cache and data cache and the 64-bit burst physical memory. Each cache presents 256-bit line transfers on its pmem port. This block grants one cache at a time, splits or assembles the line as four 64-bit beats on the burst bus, and returns a one-cycle resp to the granted cache. It sits directly downstream of both cache instances.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared physical-memory port for the icache and dcache.
// Grants one cache at a time, moves a 256-bit line as four 64-bit beats on the
// burst bus, then pulses resp to the granted cache for one cycle.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst_n,

    // icache side
    input  logic         i_pmem_read,
    input  logic [31:0]  i_pmem_address,
    output logic [255:0] i_pmem_rdata,
    output logic         i_pmem_resp,

    // dcache side
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic [255:0] d_pmem_rdata,
    output logic         d_pmem_resp,

    // burst memory side
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [31:0]  bmem_address,
    output logic [63:0]  bmem_wdata,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_resp
);

    typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst, StResp} state_e;

    state_e         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [255:0]   line_q, line_d;
    logic [31:0]    addr_q, addr_d;
    logic           grant_q, grant_d;        // 0 = icache, 1 = dcache
    logic           last_grant_q, last_grant_d;

    logic           i_req;
    logic           d_req;
    logic           pick_d;
    logic           start_write;
    logic           last_beat;
    logic [7:0]     beat_lsb;
    logic           unused_addr_bits;

    assign i_req       = i_pmem_read;
    assign d_req       = d_pmem_read | d_pmem_write;
    // On a tie the cache that was not served last wins; a lone requester always wins.
    assign pick_d      = d_req & (~i_req | ~last_grant_q);
    // A dcache read+write together is treated as a write.
    assign start_write = pick_d & d_pmem_write;
    assign last_beat   = bmem_resp & (cnt_q == 2'd3);
    assign beat_lsb    = {cnt_q, 6'd0};

    // Low address bits are dropped: transfers are always line aligned.
    assign unused_addr_bits = ^{i_pmem_address[4:0], d_pmem_address[4:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    state_d = start_write ? StWrBurst : StRdBurst;
                end
            end
            StRdBurst: begin
                if (last_beat) state_d = StResp;
            end
            StWrBurst: begin
                if (last_beat) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: grant, address latch, beat counter, line buffer.
    always_comb begin
        cnt_d        = cnt_q;
        line_d       = line_q;
        addr_d       = addr_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    grant_d      = pick_d;
                    last_grant_d = pick_d;
                    addr_d       = pick_d ? {d_pmem_address[31:5], 5'd0}
                                          : {i_pmem_address[31:5], 5'd0};
                    cnt_d        = 2'd0;
                    if (start_write) line_d = d_pmem_wdata;
                end
            end
            StRdBurst: begin
                if (bmem_resp) begin
                    line_d[beat_lsb +: 64] = bmem_rdata;
                    cnt_d                  = cnt_q + 2'd1;
                end
            end
            StWrBurst: begin
                if (bmem_resp) cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 2'd0;
            line_q       <= '0;
            addr_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        bmem_read   = (state_q == StRdBurst);
        bmem_write  = (state_q == StWrBurst);
        i_pmem_resp = (state_q == StResp) & ~grant_q;
        d_pmem_resp = (state_q == StResp) & grant_q;
    end

    assign bmem_address = addr_q;
    assign bmem_wdata   = line_q[beat_lsb +: 64];
    assign i_pmem_rdata = line_q;
    assign d_pmem_rdata = line_q;

endmodule
